// File: rtl/uart_tx_report_if.sv
// Handshake and serial-side signals of the status-report UART transmitter.
// The host side drives start and the parameters. The transmitter drives tx, busy and done.
interface uart_tx_report_if;
  logic       start;
  logic [7:0] para1;
  logic [7:0] para2;
  logic [7:0] para3;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output start, para1, para2, para3,
    input  tx, busy, done
  );

  modport slave (
    input  start, para1, para2, para3,
    output tx, busy, done
  );
endinterface

// File: rtl/uart_tx_report.sv
// 8N1 UART transmitter that sends a 5-byte status frame: the header, three
// latched parameters and an XOR checksum. The bytes are sent back-to-back, LSB first.
module uart_tx_report #(
  parameter int         BAUD_DIV = 5208,
  parameter logic [7:0] HEADER   = 8'hAA
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_report_if.slave bus
);

  localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] baud_cnt_r, baud_cnt_s;
  logic [2:0]       bit_idx_r, bit_idx_s;
  logic [2:0]       byte_idx_r, byte_idx_s;
  logic [7:0]       p1_r, p1_s, p2_r, p2_s, p3_r, p3_s, chk_r, chk_s;
  logic             tx_r, tx_s, busy_r, busy_s, done_r, done_s;
  logic [7:0]       byte_s;

  function automatic logic [7:0] frame_chk(input logic [7:0] h, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] c);
    return h ^ a ^ b ^ c;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] c,
                                            input logic [7:0] k);
    case (idx)
      3'd0:    return HEADER;
      3'd1:    return a;
      3'd2:    return b;
      3'd3:    return c;
      default: return k;
    endcase
  endfunction

  // Next-state logic and registered-output precomputation.
  always_comb begin
    state_s    = state_r;
    baud_cnt_s = baud_cnt_r;
    bit_idx_s  = bit_idx_r;
    byte_idx_s = byte_idx_r;
    p1_s       = p1_r;
    p2_s       = p2_r;
    p3_s       = p3_r;
    chk_s      = chk_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (bus.start) begin
          p1_s       = bus.para1;
          p2_s       = bus.para2;
          p3_s       = bus.para3;
          chk_s      = frame_chk(HEADER, bus.para1, bus.para2, bus.para3);
          byte_idx_s = 3'd0;
          bit_idx_s  = 3'd0;
          baud_cnt_s = '0;
          busy_s     = 1'b1;
          state_s    = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (baud_cnt_r == BAUD_LAST) begin
          baud_cnt_s = '0;
          bit_idx_s  = 3'd0;
          state_s    = DATA;
        end else begin
          baud_cnt_s = baud_cnt_r + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt_r == BAUD_LAST) begin
          baud_cnt_s = '0;
          if (bit_idx_r == 3'd7) begin
            bit_idx_s = 3'd0;
            state_s   = STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          baud_cnt_s = baud_cnt_r + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_cnt_r == BAUD_LAST) begin
          baud_cnt_s = '0;
          if (byte_idx_r < 3'd4) begin
            byte_idx_s = byte_idx_r + 3'd1;
            state_s    = START;
          end else begin
            state_s = IDLE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end
        end else begin
          baud_cnt_s = baud_cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase

    // tx is computed from the next state so the line register updates on the same edge as the FSM.
    byte_s = frame_byte(byte_idx_s, p1_s, p2_s, p3_s, chk_s);
    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = byte_s[bit_idx_s];
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
  end

  // State, counters, parameter latches and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      baud_cnt_r <= '0;
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 3'd0;
      p1_r       <= 8'd0;
      p2_r       <= 8'd0;
      p3_r       <= 8'd0;
      chk_r      <= 8'd0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      baud_cnt_r <= baud_cnt_s;
      bit_idx_r  <= bit_idx_s;
      byte_idx_r <= byte_idx_s;
      p1_r       <= p1_s;
      p2_r       <= p2_s;
      p3_r       <= p3_s;
      chk_r      <= chk_s;
      tx_r       <= tx_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign bus.tx   = tx_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_uart_tx_report.sv
// Directed bench for uart_tx_report with BAUD_DIV=4, so each frame lasts 200 cycles.
module tb_uart_tx_report;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_tx_report_if bus ();
  uart_tx_report #(.BAUD_DIV(4), .HEADER(8'hAA)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic cap_tx [200];
  int   cap_done_cnt, cap_busy_low, cap_waits;
  logic cap_ok, end_tx, end_done, end_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for tx to fall, record 200 cycles plus the following cycle; optionally inject start.
  task automatic capture(input int release_at, input int inject_at);
    cap_waits = 0; cap_ok = 1'b1; cap_done_cnt = 0; cap_busy_low = 0;
    @(negedge clk);
    while (bus.tx !== 1'b0 && cap_waits < 20) begin
      cap_waits++;
      @(negedge clk);
    end
    if (bus.tx !== 1'b0) begin
      cap_ok = 1'b0;
      check("tx_fall_timeout", 32'(bus.tx), 32'd0);
    end else begin
      for (int i = 0; i < 200; i++) begin
        if (i > 0) @(negedge clk);
        cap_tx[i] = bus.tx;
        if (bus.done === 1'b1) cap_done_cnt++;
        if (bus.busy !== 1'b1) cap_busy_low++;
        if (i == release_at) bus.start = 1'b0;
        if (i == inject_at) begin
          bus.start = 1'b1;
          bus.para1 = 8'h11; bus.para2 = 8'h22; bus.para3 = 8'h33;
        end
        if (inject_at >= 0 && i == inject_at + 1) bus.start = 1'b0;
      end
      @(negedge clk);
      end_tx = bus.tx; end_done = bus.done; end_busy = bus.busy;
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    logic [7:0] exp_b [5];
    logic [7:0] got;
    int unstable, framing;
    if (cap_ok) begin
      exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2; exp_b[3] = e3; exp_b[4] = e4;
      unstable = 0; framing = 0;
      for (int b = 0; b < 5; b++) begin
        got = 8'h00;
        for (int j = 0; j < 10; j++) begin
          int base;
          base = (b * 10 + j) * 4;
          for (int s = 1; s < 4; s++)
            if (cap_tx[base + s] !== cap_tx[base]) unstable++;
          if (j == 0) begin
            if (cap_tx[base] !== 1'b0) framing++;
          end else if (j == 9) begin
            if (cap_tx[base] !== 1'b1) framing++;
          end else begin
            got[j - 1] = cap_tx[base];
          end
        end
        check($sformatf("%s_byte%0d", tag, b), 32'(got), 32'(exp_b[b]));
      end
      check({tag, "_bit_stable"}, 32'(unstable), 32'd0);
      check({tag, "_framing"}, 32'(framing), 32'd0);
      check({tag, "_busy_in_frame"}, 32'(cap_busy_low), 32'd0);
      check({tag, "_done_early"}, 32'(cap_done_cnt), 32'd0);
      check({tag, "_done_at_200"}, 32'(end_done), 32'd1);
      check({tag, "_busy_fall_200"}, 32'(end_busy), 32'd0);
      check({tag, "_tx_idle_200"}, 32'(end_tx), 32'd1);
    end
  endtask

  task automatic pulse_start(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    @(negedge clk);
    bus.para1 = a; bus.para2 = b; bus.para3 = c;
    bus.start = 1'b1;
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [9:0] hdr;
    bus.start = 1'b0; bus.para1 = 8'h00; bus.para2 = 8'h00; bus.para3 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(bus.tx), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    check_quiet("idle_after_rst", 5);

    // Basic frame; checksum AA^01^0A^03 = A2.
    pulse_start(8'h01, 8'h0A, 8'h03);
    capture(0, -1);
    check("basic_waits", 32'(cap_waits), 32'd0);
    check_frame("basic", 8'hAA, 8'h01, 8'h0A, 8'h03, 8'hA2);
    for (int i = 0; i < 10; i++) hdr[i] = cap_tx[i * 4];
    check("header_pattern", 32'(hdr), 32'(10'b1101010100));
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check_quiet("basic_quiet", 10);

    // start with new parameters at cycle 50 of the frame is ignored.
    pulse_start(8'h01, 8'h0A, 8'h03);
    capture(0, 50);
    check_frame("ignore", 8'hAA, 8'h01, 8'h0A, 8'h03, 8'hA2);
    check_quiet("ignore_no_second", 20);

    // start held high: two frames with one idle cycle between them; checksum AA^5A^C3^0F = 3C.
    pulse_start(8'h5A, 8'hC3, 8'h0F);
    capture(-1, -1);
    check_frame("b2b1", 8'hAA, 8'h5A, 8'hC3, 8'h0F, 8'h3C);
    capture(10, -1);
    check("b2b_gap", 32'(cap_waits), 32'd0);
    check_frame("b2b2", 8'hAA, 8'h5A, 8'hC3, 8'h0F, 8'h3C);
    check_quiet("b2b_no_third", 20);

    // Reset during byte 2's start bit forces tx high at once.
    pulse_start(8'h01, 8'h0A, 8'h03);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (81) @(negedge clk);
    check("pre_rst_tx_low", 32'(bus.tx), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx", 32'(bus.tx), 32'd1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check_quiet("midrst_hold", 5);
    rst = 1'b0;
    check_quiet("after_rst_idle", 3);
    // Checksum AA^FF^00^55 = 00.
    pulse_start(8'hFF, 8'h00, 8'h55);
    capture(0, -1);
    check_frame("fresh", 8'hAA, 8'hFF, 8'h00, 8'h55, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
